// File: rtl/reg_bank_loader_pkg.sv
// reg_bank_loader_pkg: state encoding and default bank geometry shared by loader and bank
package reg_bank_loader_pkg;
  localparam int DEF_NR_OF_BITS = 8;
  localparam int DEF_NR_OF_REGS = 4;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    SHIFT  = 3'd2,
    COMMIT = 3'd3,
    DONE   = 3'd4,
    READ   = 3'd5
  } state_t;
endpackage

// File: rtl/reg_bank_loader_bit_packer.sv
// reg_bank_loader_bit_packer: MSB-first serial-to-word packer with zero-pad on last bit
// Ports: Clock/Reset_n; clear restarts the word; take accepts s_bit (s_last marks frame end);
// word is the left-aligned word including the bit being taken; word_end says that bit ends a word.
module reg_bank_loader_bit_packer
  import reg_bank_loader_pkg::*;
#(
  parameter int NrOfBits = DEF_NR_OF_BITS
) (
  input  logic                Clock,
  input  logic                Reset_n,
  input  logic                clear,
  input  logic                take,
  input  logic                s_bit,
  input  logic                s_last,
  output logic [NrOfBits-1:0] word,
  output logic                word_end
);
  localparam int CntBits = $clog2(NrOfBits + 1);
  logic [NrOfBits-1:0] sh, sh_next;
  logic [CntBits-1:0]  bit_cnt, cnt_next;
  // Shifting left by the number of missing bits left-aligns a short final word.
  always_comb begin
    sh_next  = {sh[NrOfBits-2:0], s_bit};
    cnt_next = bit_cnt + 1'b1;
    word     = sh_next << (CntBits'(NrOfBits) - cnt_next);
    word_end = (cnt_next == CntBits'(NrOfBits)) || s_last;
  end
  always_ff @(posedge Clock or negedge Reset_n)
    if (!Reset_n) begin
      sh      <= '0;
      bit_cnt <= '0;
    end else if (clear) begin
      sh      <= '0;
      bit_cnt <= '0;
    end else if (take) begin
      sh      <= sh_next;
      bit_cnt <= word_end ? '0 : cnt_next;
    end
endmodule

// File: rtl/reg_bank_loader.sv
// reg_bank_loader: packs a serial bit stream into words and writes them into a register bank
// Ports: Clock/Reset_n; s_valid/s_bit/s_last/s_ready serial input; rd_req/rd_idx readback request;
// ClockEnable/D/Tick bank write port; clr bank clear; cs per-register output disable; frame_done pulse.
module reg_bank_loader
  import reg_bank_loader_pkg::*;
#(
  parameter int NrOfBits = DEF_NR_OF_BITS,
  parameter int NrOfRegs = DEF_NR_OF_REGS,
  parameter int IdxBits  = $clog2(NrOfRegs)
) (
  input  logic                Clock,
  input  logic                Reset_n,
  input  logic                s_valid,
  input  logic                s_bit,
  input  logic                s_last,
  output logic                s_ready,
  input  logic                rd_req,
  input  logic [IdxBits-1:0]  rd_idx,
  output logic [NrOfRegs-1:0] ClockEnable,
  output logic [NrOfBits-1:0] D,
  output logic                Tick,
  output logic                clr,
  output logic [NrOfRegs-1:0] cs,
  output logic                frame_done
);
  state_t              state;
  logic [IdxBits-1:0]  wr_ptr;
  logic                last_seen;
  logic [NrOfBits-1:0] word;
  logic                word_end;
  logic                take;
  // s_ready is high exactly while in SHIFT, so it doubles as the accept qualifier.
  assign take = s_valid && s_ready;
  reg_bank_loader_bit_packer #(.NrOfBits(NrOfBits)) u_packer (
    .Clock    (Clock),
    .Reset_n  (Reset_n),
    .clear    (state == CLEAR),
    .take     (take),
    .s_bit    (s_bit),
    .s_last   (s_last),
    .word     (word),
    .word_end (word_end)
  );
  always_ff @(posedge Clock or negedge Reset_n)
    if (!Reset_n) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      last_seen   <= 1'b0;
      s_ready     <= 1'b0;
      ClockEnable <= '0;
      D           <= '0;
      Tick        <= 1'b0;
      clr         <= 1'b0;
      cs          <= '1;
      frame_done  <= 1'b0;
    end else begin
      clr         <= 1'b0;
      Tick        <= 1'b0;
      ClockEnable <= '0;
      frame_done  <= 1'b0;
      cs          <= '1;
      case (state)
        IDLE:
          if (s_valid) begin
            state <= CLEAR;
            clr   <= 1'b1;
          end else if (rd_req) begin
            state <= READ;
            cs    <= ~(NrOfRegs'(1) << rd_idx);
          end
        CLEAR: begin
          state     <= SHIFT;
          s_ready   <= 1'b1;
          wr_ptr    <= '0;
          last_seen <= 1'b0;
        end
        SHIFT:
          if (take && word_end) begin
            state       <= COMMIT;
            s_ready     <= 1'b0;
            D           <= word;
            ClockEnable <= NrOfRegs'(1) << wr_ptr;
            Tick        <= 1'b1;
            last_seen   <= s_last;
          end
        COMMIT:
          if (last_seen || wr_ptr == IdxBits'(NrOfRegs - 1)) begin
            state      <= DONE;
            frame_done <= 1'b1;
          end else begin
            state   <= SHIFT;
            s_ready <= 1'b1;
            wr_ptr  <= wr_ptr + 1'b1;
          end
        DONE:    state <= IDLE;
        READ:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule
